adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits, at least 2.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth, at least 1; WIDTH SHALL be divisible by STAGES. Each stage handles a slice of WIDTH/STAGES bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present on a, b, sub.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 sub  input  1  0 selects a+b; 1 selects a-b.
REQ-010 out_valid  output  1  result outputs hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carry_out  output  1  unsigned carry out of the MSB; for subtraction, 1 means no borrow.
REQ-014 overflow  output  1  signed two's-complement overflow of the operation.

Function
REQ-015 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-016 Global advance SHALL be: adv = !out_valid || out_ready. in_ready SHALL equal adv, combinationally.
REQ-017 When adv=1, every stage register SHALL load from the stage before it. The stage-1 valid bit SHALL load in_valid.
REQ-018 When adv=0, every stage register, including valid bits and partial results, SHALL hold its value.
REQ-019 Subtraction SHALL be computed as a + ~b + 1. The inverted b and carry-in 1 SHALL be applied at stage 1.
REQ-020 Stage k (k=1..STAGES) SHALL add slice k-1 of the operands with the carry registered from stage k-1; stage 1 takes the carry-in.
REQ-021 Unprocessed operand slices and completed sum slices SHALL travel with their valid bit through the pipeline.
REQ-022 Latency with no stalls SHALL be exactly STAGES cycles from the accepting edge to out_valid=1.
REQ-023 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-024 Bubbles (invalid stages) are not compressed. Order of results SHALL equal order of acceptance.
REQ-025 carry_out SHALL be the carry out of bit WIDTH-1.
REQ-026 overflow SHALL be (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-027 sum, carry_out and overflow SHALL be registered outputs of the final stage. They SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 With STAGES=1 the block SHALL act as a single registered adder with the same handshake.
REQ-029 Outputs while out_valid=0 are don't-care, except after reset (REQ-030).

Reset
REQ-030 While reset=1, out_valid and all stage valid bits SHALL be 0, and sum, carry_out, overflow SHALL be 0. This SHALL take effect immediately, without waiting for a clock edge.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations, with no partial result emitted.
REQ-032 in_ready SHALL be 1 during and after reset, per REQ-016.
REQ-033 The first operation accepted after reset release SHALL complete with normal latency.

Verification (WIDTH=16, STAGES=2 unless noted)
REQ-034 Add a=0x7FFF, b=0x0001, out_ready=1 -> 2 cycles later sum=0x8000, carry_out=0, overflow=1.
REQ-035 Add 0xFFFF+0x0001 -> sum=0x0000, carry_out=1, overflow=0. The carry SHALL cross the stage boundary between bits 7 and 8.
REQ-036 Subtract 0x0000-0x0001 -> sum=0xFFFF, carry_out=0, overflow=0. Subtract 0x8000-0x0001 -> sum=0x7FFF, carry_out=1, overflow=1.
REQ-037 Stream 8 back-to-back operations and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, the held result is unchanged, and all 8 results arrive in order with none lost or duplicated.
REQ-038 Assert reset for 1 cycle with 2 operations in flight -> out_valid=0 immediately, no stale result after release, and the next operation has 2-cycle latency.
REQ-039 Repeat REQ-034 through REQ-037 with WIDTH=32, STAGES=4 (latency 4) and with WIDTH=8, STAGES=1 (latency 1), comparing against a reference model over 10000 random operand/sub/stall combinations.

Source files
------------

// File: rtl/adder_pipe.sv
// Pipelined ripple adder/subtractor: each stage adds one WIDTH/STAGES slice and registers the carry.
// Operands, partial sums and carries advance together under a single global valid/ready stall.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;

  logic             w_adv;

  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_ovf;

  logic             w_v_d  [STAGES];
  logic [WIDTH-1:0] w_a_d  [STAGES];
  logic [WIDTH-1:0] w_b_d  [STAGES];
  logic [WIDTH-1:0] w_s_d  [STAGES];
  logic             w_c_d  [STAGES];
  logic             w_ci   [STAGES];
  logic [SW:0]      w_slc  [STAGES];
  logic             w_ovf_d;

  assign w_adv     = !r_v[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign carry_out = r_c[STAGES-1];
  assign overflow  = r_ovf;

  always_comb begin
    // Subtraction is a + ~b + 1: b is inverted once here and the +1 enters as stage-1 carry-in.
    w_v_d[0] = in_valid;
    w_a_d[0] = a;
    w_b_d[0] = sub ? ~b : b;
    w_s_d[0] = '0;
    w_ci[0]  = sub;
    for (int k = 1; k < STAGES; k++) begin
      w_v_d[k] = r_v[k-1];
      w_a_d[k] = r_a[k-1];
      w_b_d[k] = r_b[k-1];
      w_s_d[k] = r_s[k-1];
      w_ci[k]  = r_c[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_slc[k] = {1'b0, w_a_d[k][k*SW +: SW]} + {1'b0, w_b_d[k][k*SW +: SW]}
               + (SW+1)'(w_ci[k]);
      w_s_d[k][k*SW +: SW] = w_slc[k][SW-1:0];
      w_c_d[k] = w_slc[k][SW];
    end
    // a^b^s at the MSB recovers the carry into that bit.
    w_ovf_d = w_a_d[STAGES-1][WIDTH-1] ^ w_b_d[STAGES-1][WIDTH-1]
            ^ w_s_d[STAGES-1][WIDTH-1] ^ w_c_d[STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_v_d[k];
        r_a[k] <= w_a_d[k];
        r_b[k] <= w_b_d[k];
        r_s[k] <= w_s_d[k];
        r_c[k] <= w_c_d[k];
      end
      r_ovf <= w_ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: three configurations (16/2, 32/4, 8/1) run concurrently, each with
// directed vectors, a mid-flight reset, a stalled 8-op stream and a long random stream.
module tb_adder_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input int g, input string name, input logic [33:0] act,
                       input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cfg%0d %s: got %h expected %h", g, name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, packed as {overflow, carry, sum}.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic sub);
    longint ua, ub, sa, sb, r, sr, lim;
    logic   c, v;
    lim = longint'(1) << w;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[w-1] ? ua - lim : ua;
    sb  = b[w-1] ? ub - lim : ub;
    if (sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= lim);
      sr = sa + sb;
    end
    v = (sr >= lim / 2) || (sr < -(lim / 2));
    r = r & (lim - 1);
    return {v, c, r[31:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 0) ? 16 : (g == 1) ? 32 : 8;
    localparam int S = (g == 0) ? 2 : (g == 1) ? 4 : 1;

    logic         rst, in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
    logic [W-1:0] a, b, sum;
    logic         done = 1'b0;
    logic [33:0]  q[$];
    vec_t         tbl[8];
    logic [31:0]  m, mn;
    int           n, sent, recv, cyc, nops;
    logic         held;
    logic [33:0]  held_val, e;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .carry_out(carry_out), .overflow(overflow)
    );

    initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
      #3;
      check(g, "reset out_valid", 34'(out_valid), 34'(0));
      check(g, "reset outputs", {overflow, carry_out, 32'(sum)}, 34'(0));
      check(g, "reset in_ready", 34'(in_ready), 34'(1));
      @(negedge clk); rst = 1'b0;

      m  = 32'((64'd1 << W) - 1);
      mn = 32'd1 << (W - 1);
      tbl[0] = '{a: mn - 1, b: 1,      sub: 0, s: mn,     c: 0, v: 1};
      tbl[1] = '{a: m,      b: 1,      sub: 0, s: 0,      c: 1, v: 0};
      tbl[2] = '{a: 0,      b: 1,      sub: 1, s: m,      c: 0, v: 0};
      tbl[3] = '{a: mn,     b: 1,      sub: 1, s: mn - 1, c: 1, v: 1};
      tbl[4] = '{a: 5,      b: 3,      sub: 0, s: 8,      c: 0, v: 0};
      tbl[5] = '{a: 3,      b: 5,      sub: 1, s: m - 1,  c: 0, v: 0};
      tbl[6] = '{a: m,      b: m,      sub: 1, s: 0,      c: 1, v: 0};
      tbl[7] = '{a: mn,     b: mn,     sub: 0, s: 0,      c: 1, v: 1};

      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        a = W'(tbl[i].a); b = W'(tbl[i].b); sub = tbl[i].sub; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check(g, $sformatf("vec%0d latency", i), 34'(n), 34'(S));
        check(g, $sformatf("vec%0d result", i), {overflow, carry_out, 32'(sum)},
              {tbl[i].v, tbl[i].c, tbl[i].s});
      end

      // Two operations in flight, then reset between edges.
      @(negedge clk); a = W'(1); b = W'(2); sub = 1'b0; in_valid = 1'b1;
      @(negedge clk); a = W'(3); b = W'(4);
      @(posedge clk); #2 in_valid = 1'b0; rst = 1'b1;
      #1;
      check(g, "midreset out_valid", 34'(out_valid), 34'(0));
      check(g, "midreset outputs", {overflow, carry_out, 32'(sum)}, 34'(0));
      check(g, "midreset in_ready", 34'(in_ready), 34'(1));
      @(negedge clk); rst = 1'b0;
      n = 0;
      repeat (S + 3) begin @(posedge clk); #1; if (out_valid) n++; end
      check(g, "stale after reset", 34'(n), 34'(0));
      @(negedge clk);
      a = W'(tbl[0].a); b = W'(tbl[0].b); sub = tbl[0].sub; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check(g, "post-reset latency", 34'(n), 34'(S));
      check(g, "post-reset result", {overflow, carry_out, 32'(sum)},
            {tbl[0].v, tbl[0].c, tbl[0].s});
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;

      // Phase 0: 8 back-to-back ops with a 3-cycle stall; phase 1: random traffic.
      for (int phase = 0; phase < 2; phase++) begin
        nops = (phase == 0) ? 8 : 10000;
        sent = 0; recv = 0; cyc = 0; held = 1'b0; held_val = '0;
        while ((sent < nops || q.size() > 0) && cyc < 4 * nops + 100) begin
          @(negedge clk);
          if (phase == 0) begin
            in_valid  = (sent < nops);
            out_ready = !(cyc >= 4 && cyc < 7);
          end else begin
            in_valid  = (sent < nops) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
          end
          a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(1));
          #1;
          check(g, "in_ready rule", 34'(in_ready), 34'(!out_valid || out_ready));
          if (held) begin
            check(g, "stall valid held", 34'(out_valid), 34'(1));
            check(g, "stall result held", {overflow, carry_out, 32'(sum)}, held_val);
          end
          if (in_valid && in_ready) begin
            q.push_back(ref_op(W, 32'(a), 32'(b), sub));
            sent++;
          end
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              check(g, "unexpected result", 34'(1), 34'(0));
            end else begin
              e = q.pop_front();
              check(g, $sformatf("stream%0d result %0d", phase, recv),
                    {overflow, carry_out, 32'(sum)}, e);
            end
            recv++;
          end
          held     = out_valid && !out_ready;
          held_val = {overflow, carry_out, 32'(sum)};
          cyc++;
        end
        check(g, $sformatf("stream%0d received", phase), 34'(recv), 34'(nops));
        check(g, $sformatf("stream%0d pending", phase), 34'(q.size()), 34'(0));
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
      end
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (!(cfg[0].done && cfg[1].done && cfg[2].done)) begin
      bad++;
      total++;
      $display("FAIL timeout: got done=%b%b%b expected 111",
               cfg[2].done, cfg[1].done, cfg[0].done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
